// File: rtl/user_seq_pkg.sv
// rtl/user_seq_pkg.sv - shared types and constants for the user port sequencer
package user_seq_pkg;

   typedef enum logic [3:0] {
      IDLE,
      LOAD,
      RELEASE,
      RUN,
      FLUSH,
      DUMP_RD,
      DUMP_WAIT,
      DUMP_OUT,
      DONE
   } seq_state_t;

   localparam logic [31:0] NOP_WORD        = 32'h0000_0000;
   localparam int          USER_ADDR_W     = 13;
   localparam int          SEQ_CNT_W       = 32;
   localparam int          NOP_MASK_CYCLES = 3;

endpackage

// File: rtl/seq_sat_counter.sv
// rtl/seq_sat_counter.sv - up-counter with clear/enable that parks at its terminal value
module seq_sat_counter
   import user_seq_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 en,
   input  logic [SEQ_CNT_W-1:0] terminal,
   output logic [SEQ_CNT_W-1:0] count,
   output logic                 tc
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (en && (count != terminal)) begin
         count <= count + SEQ_CNT_W'(1);
      end
   end

   assign tc = (count == terminal);

endmodule

// File: rtl/user_port_sequencer.sv
// rtl/user_port_sequencer.sv - loads memory, runs the CPU until NOP, flushes, then dumps memory
module user_port_sequencer
   import user_seq_pkg::*;
#(
   parameter int          LOAD_WORDS     = 20,
   parameter int          DUMP_WORDS     = 64,
   parameter int          FLUSH_CYCLES   = 1000,
   parameter int          RELEASE_CYCLES = 3,
   parameter logic [31:0] MAX_RUN        = 32'd1000000,
   parameter int          ADDR_W         = USER_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [31:0]       load_data,
   output logic              cpu_rst,
   input  logic [31:0]       instruction,
   output logic [ADDR_W-1:0] user_addr,
   output logic              user_we,
   output logic [31:0]       user_din,
   input  logic [31:0]       user_dout,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [ADDR_W-1:0] dump_addr,
   output logic [31:0]       dump_data,
   output logic [31:0]       run_cycles,
   output logic              timeout,
   output logic              done
);

   if (LOAD_WORDS < 0 || LOAD_WORDS > (1 << ADDR_W) || DUMP_WORDS < 1 || DUMP_WORDS > (1 << ADDR_W))
   begin : g_param_check
      $error("user_port_sequencer: LOAD_WORDS/DUMP_WORDS out of range for ADDR_W");
   end

   localparam logic [ADDR_W-1:0] LAST_LOAD = ADDR_W'((LOAD_WORDS > 0) ? LOAD_WORDS - 1 : 0);
   localparam logic [ADDR_W-1:0] LAST_DUMP = ADDR_W'(DUMP_WORDS - 1);
   localparam logic [31:0]       FLUSH_TC  = (FLUSH_CYCLES > 0) ? 32'(FLUSH_CYCLES - 1) : 32'd0;

   seq_state_t        state, state_d;
   logic [ADDR_W-1:0] idx, idx_d;
   logic              load_ready_d, user_we_d, cpu_rst_d, dump_valid_d, timeout_d, done_d;
   logic [ADDR_W-1:0] user_addr_d, dump_addr_d;
   logic [31:0]       user_din_d, dump_data_d, run_cycles_d;

   logic [31:0] run_count, unused_rel_count, unused_flush_count;
   logic        rel_tc, run_tc, flush_tc;

   seq_sat_counter u_rel_cnt (
      .clk(clk), .rst(rst), .clr(state != RELEASE), .en(state == RELEASE),
      .terminal(32'(RELEASE_CYCLES)), .count(unused_rel_count), .tc(rel_tc)
   );

   seq_sat_counter u_run_cnt (
      .clk(clk), .rst(rst), .clr(state != RUN), .en(state == RUN),
      .terminal(MAX_RUN), .count(run_count), .tc(run_tc)
   );

   seq_sat_counter u_flush_cnt (
      .clk(clk), .rst(rst), .clr(state != FLUSH), .en(state == FLUSH),
      .terminal(FLUSH_TC), .count(unused_flush_count), .tc(flush_tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         idx        <= '0;
         load_ready <= 1'b0;
         user_we    <= 1'b0;
         user_addr  <= '0;
         user_din   <= '0;
         cpu_rst    <= 1'b1;
         dump_valid <= 1'b0;
         dump_addr  <= '0;
         dump_data  <= '0;
         run_cycles <= '0;
         timeout    <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_d;
         idx        <= idx_d;
         load_ready <= load_ready_d;
         user_we    <= user_we_d;
         user_addr  <= user_addr_d;
         user_din   <= user_din_d;
         cpu_rst    <= cpu_rst_d;
         dump_valid <= dump_valid_d;
         dump_addr  <= dump_addr_d;
         dump_data  <= dump_data_d;
         run_cycles <= run_cycles_d;
         timeout    <= timeout_d;
         done       <= done_d;
      end
   end

   always_comb begin
      state_d      = state;
      idx_d        = idx;
      load_ready_d = 1'b0;
      user_we_d    = 1'b0;
      user_addr_d  = user_addr;
      user_din_d   = user_din;
      cpu_rst_d    = cpu_rst;
      dump_valid_d = dump_valid;
      dump_addr_d  = dump_addr;
      dump_data_d  = dump_data;
      run_cycles_d = run_cycles;
      timeout_d    = timeout;
      done_d       = done;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               done_d       = 1'b0;
               timeout_d    = 1'b0;
               run_cycles_d = '0;
               idx_d        = '0;
               cpu_rst_d    = 1'b1;
               if (LOAD_WORDS == 0) begin
                  state_d = RELEASE;
               end else begin
                  state_d      = LOAD;
                  load_ready_d = 1'b1;
               end
            end
         end
         LOAD: begin
            load_ready_d = 1'b1;
            if (load_valid && load_ready) begin
               user_we_d   = 1'b1;
               user_addr_d = idx;
               user_din_d  = load_data;
               if (idx == LAST_LOAD) begin
                  load_ready_d = 1'b0;
                  state_d      = RELEASE;
               end else begin
                  idx_d = idx + ADDR_W'(1);
               end
            end
         end
         RELEASE: begin
            if (rel_tc) begin
               cpu_rst_d = 1'b0;
               state_d   = RUN;
            end
         end
         RUN: begin
            // The pipeline shows stale zero instructions right after reset release.
            if (run_tc) begin
               timeout_d    = 1'b1;
               run_cycles_d = run_count;
               state_d      = FLUSH;
            end else if (run_count >= 32'(NOP_MASK_CYCLES) && instruction == NOP_WORD) begin
               run_cycles_d = run_count;
               state_d      = FLUSH;
            end
         end
         FLUSH: begin
            if (flush_tc) begin
               idx_d       = '0;
               user_addr_d = '0;
               state_d     = DUMP_RD;
            end
         end
         DUMP_RD: state_d = DUMP_WAIT;
         DUMP_WAIT: begin
            dump_data_d  = user_dout;
            dump_addr_d  = idx;
            dump_valid_d = 1'b1;
            state_d      = DUMP_OUT;
         end
         DUMP_OUT: begin
            if (dump_ready) begin
               dump_valid_d = 1'b0;
               if (idx == LAST_DUMP) begin
                  done_d    = 1'b1;
                  cpu_rst_d = 1'b1;
                  state_d   = DONE;
               end else begin
                  idx_d       = idx + ADDR_W'(1);
                  user_addr_d = idx + ADDR_W'(1);
                  state_d     = DUMP_RD;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_user_port_sequencer.sv
// tb/tb_user_port_sequencer.sv - directed bench for user_port_sequencer with a synchronous memory model
module tb_user_port_sequencer;

   localparam int          LW = 20;
   localparam int          DW = 64;
   localparam int          FC = 10;
   localparam int          RC = 3;
   localparam int          AW = 13;
   localparam logic [31:0] MR = 32'd100;

   logic          clk = 1'b0;
   logic          rst, start, load_valid, load_ready, cpu_rst, user_we;
   logic          dump_valid, dump_ready, timeout, done;
   logic [31:0]   load_data, instruction, user_din, user_dout, dump_data, run_cycles;
   logic [AW-1:0] user_addr, dump_addr;
   logic [AW-1:0] rd_addr_q = '0;

   int n_checks = 0;
   int n_fail   = 0;

   user_port_sequencer #(
      .LOAD_WORDS(LW), .DUMP_WORDS(DW), .FLUSH_CYCLES(FC),
      .RELEASE_CYCLES(RC), .MAX_RUN(MR), .ADDR_W(AW)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
      .cpu_rst(cpu_rst), .instruction(instruction),
      .user_addr(user_addr), .user_we(user_we), .user_din(user_din), .user_dout(user_dout),
      .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr), .dump_data(dump_data),
      .run_cycles(run_cycles), .timeout(timeout), .done(done)
   );

   always #5 clk = ~clk;

   // Memory returns addr*3 one cycle after the address is presented.
   always @(posedge clk) rd_addr_q <= user_addr;
   assign user_dout = 32'(rd_addr_q) * 32'd3;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state(input string pfx);
      check_eq({pfx, "_cpu_rst"},    cpu_rst,    1);
      check_eq({pfx, "_user_we"},    user_we,    0);
      check_eq({pfx, "_load_ready"}, load_ready, 0);
      check_eq({pfx, "_dump_valid"}, dump_valid, 0);
      check_eq({pfx, "_done"},       done,       0);
      check_eq({pfx, "_timeout"},    timeout,    0);
      check_eq({pfx, "_run_cycles"}, run_cycles, 0);
      check_eq({pfx, "_user_addr"},  user_addr,  0);
      check_eq({pfx, "_user_din"},   user_din,   0);
      check_eq({pfx, "_dump_addr"},  dump_addr,  0);
      check_eq({pfx, "_dump_data"},  dump_data,  0);
   endtask

   task automatic run_seq(input bit toggle, input int nop_cycle, input int abort_beat,
                          input logic [31:0] exp_run, input bit exp_to);
      int            k, w, cyc, last_we, r, f, b;
      logic          hs, prev_hs, stalled, prev_dhs;
      logic [31:0]   held_d;
      logic [AW-1:0] held_a;

      start = 1'b1;
      tick();
      start = 1'b0;
      check_eq("clr_done", done, 0);
      check_eq("clr_run", run_cycles, 0);
      check_eq("clr_to", timeout, 0);

      // load and release: model tracks handshakes k and observed writes w
      k = 0; w = 0; cyc = 0; last_we = 0; prev_hs = 1'b0;
      while (cpu_rst && cyc < 300) begin
         check_eq("we", user_we, prev_hs);
         if (user_we) begin
            check_eq("waddr", user_addr, w);
            check_eq("wdata", user_din, w + 1);
            w++;
            last_we = cyc;
         end
         check_eq("load_ready", load_ready, k < LW);
         load_valid = toggle ? ((cyc % 2) == 1) : 1'b1;
         load_data  = 32'(k + 1);
         hs         = load_valid && (k < LW);
         prev_hs    = hs;
         if (hs) k++;
         tick();
         cyc++;
      end
      load_valid = 1'b0;
      check_eq("load_end", cpu_rst, 0);
      check_eq("nwrites", w, LW);
      check_eq("rel_gap", cyc - last_we, RC + 1);

      // run: r is the run cycle index of the cycle being driven
      r = 0;
      while (run_cycles == 0 && r < 300) begin
         check_eq("run_cpu_rst", cpu_rst, 0);
         check_eq("run_ld_rdy", load_ready, 0);
         check_eq("run_we", user_we, 0);
         start       = (r == 10);
         instruction = ((nop_cycle >= 0 && r == 2) || r == nop_cycle) ? 32'h0 : 32'h2008_0005;
         tick();
         r++;
      end
      start       = 1'b0;
      instruction = 32'h2008_0005;
      check_eq("run_cycles", run_cycles, exp_run);
      check_eq("timeout", timeout, exp_to);
      check_eq("detect_lat", r, exp_run + 1);

      // FLUSH_CYCLES of flush, then DUMP_RD and DUMP_WAIT before dump_valid shows
      f = 0;
      while (!dump_valid && f < 100) begin
         check_eq("flush_cpu_rst", cpu_rst, 0);
         tick();
         f++;
      end
      check_eq("flush_gap", f, FC + 2);

      b = 0; cyc = 0; stalled = 1'b0; prev_dhs = 1'b0; held_d = '0; held_a = '0;
      while (b < DW && cyc < 3000) begin
         if (prev_dhs) check_eq("dv_drop", dump_valid, 0);
         if (stalled) begin
            check_eq("stall_valid", dump_valid, 1);
            check_eq("stall_data", dump_data, held_d);
            check_eq("stall_addr", dump_addr, held_a);
         end
         if (dump_valid && !stalled) begin
            check_eq("dump_addr", dump_addr, b);
            check_eq("dump_data", dump_data, 32'(b * 3));
         end
         if (dump_valid && b == abort_beat) begin
            dump_ready = 1'b0;
            rst        = 1'b1;
            tick();
            rst = 1'b0;
            check_reset_state("abort");
            return;
         end
         dump_ready = ($urandom_range(0, 2) != 0);
         prev_dhs   = dump_valid && dump_ready;
         stalled    = dump_valid && !dump_ready;
         held_d     = dump_data;
         held_a     = dump_addr;
         if (prev_dhs) b++;
         tick();
         cyc++;
      end
      dump_ready = 1'b0;
      check_eq("ndump", b, DW);
      check_eq("done", done, 1);
      check_eq("done_cpu_rst", cpu_rst, 1);
      check_eq("done_dv", dump_valid, 0);
      check_eq("hold_run", run_cycles, exp_run);
      check_eq("hold_to", timeout, exp_to);
   endtask

   initial begin
      rst         = 1'b1;
      start       = 1'b0;
      load_valid  = 1'b0;
      load_data   = '0;
      dump_ready  = 1'b0;
      instruction = 32'h2008_0005;
      repeat (3) tick();
      check_reset_state("reset");
      rst = 1'b0;
      tick();
      check_eq("idle_cpu_rst", cpu_rst, 1);

      run_seq(1'b0, 57, -1, 32'd57, 1'b0);
      run_seq(1'b1, -1, -1, 32'd100, 1'b1);
      run_seq(1'b0, 57, 5, 32'd57, 1'b0);
      run_seq(1'b1, 20, -1, 32'd20, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
